vga_controller: RTL and testbench

- Free-running VGA timing generator; single clock domain.
- Produces horizontal/vertical sync, pixel coordinates and an active-video flag for a downstream pixel/colour generator.
- Default timing is VESA 800x600 @ 72 Hz with a 50 MHz clock (pixel clock = clk, one pixel per cycle).
- All timing values are parameters, so other modes need only a re-parameterisation.

---
 rtl/vga_controller.sv | 120 ++++++++++++
 tb/tb_vga_controller.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_controller.sv
// VGA timing generator: free-running h/v counters with registered sync/active decode.
// Define VGA_FRAME_CNT_EN to add the 16-bit frame_count output.
`timescale 1ns/1ps
module vga_controller #(
   parameter int H_ACTIVE   = 800,
   parameter int H_FP       = 56,
   parameter int H_SYNC     = 120,
   parameter int H_BP       = 64,
   parameter int V_ACTIVE   = 600,
   parameter int V_FP       = 37,
   parameter int V_SYNC     = 6,
   parameter int V_BP       = 23,
   parameter int H_SYNC_POL = 1,
   parameter int V_SYNC_POL = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        hsync,
   output logic        vsync,
   output logic [10:0] hcount,
   output logic [9:0]  vcount,
   output logic        active_video
`ifdef VGA_FRAME_CNT_EN
   ,
   output logic [15:0] frame_count
`endif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (H_TOTAL > 2048 || H_TOTAL < 1) begin : g_bad_h_total
      $error("vga_controller: H_TOTAL must be 1..2048");
   end
   if (V_TOTAL > 1024 || V_TOTAL < 1) begin : g_bad_v_total
      $error("vga_controller: V_TOTAL must be 1..1024");
   end

   localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0] HA_LAST  = 11'(H_ACTIVE - 1);
   localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0]  VA_LAST  = 10'(V_ACTIVE - 1);
   localparam logic [9:0]  VS_FIRST = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic        HPOL     = (H_SYNC_POL != 0);
   localparam logic        VPOL     = (V_SYNC_POL != 0);

   logic [10:0] r_hcount;
   logic [9:0]  r_vcount;
   logic        r_hsync;
   logic        r_vsync;
   logic        r_active;

   logic        w_h_wrap;
   logic        w_v_wrap;
   logic [10:0] w_hcount_nxt;
   logic [9:0]  w_vcount_nxt;
   logic        w_hsync_nxt;
   logic        w_vsync_nxt;
   logic        w_active_nxt;

   // Outputs are decoded from the next counter values so they register
   // in lock-step with the coordinates they describe.
   always_comb begin
      w_h_wrap     = (r_hcount == H_LAST);
      w_v_wrap     = (r_vcount == V_LAST);
      w_hcount_nxt = w_h_wrap ? 11'd0 : r_hcount + 11'd1;
      w_vcount_nxt = r_vcount;
      if (w_h_wrap) begin
         w_vcount_nxt = w_v_wrap ? 10'd0 : r_vcount + 10'd1;
      end
      w_hsync_nxt  = ((w_hcount_nxt >= HS_FIRST) && (w_hcount_nxt <= HS_LAST))
                     ? HPOL : ~HPOL;
      w_vsync_nxt  = ((w_vcount_nxt >= VS_FIRST) && (w_vcount_nxt <= VS_LAST))
                     ? VPOL : ~VPOL;
      w_active_nxt = (w_hcount_nxt <= HA_LAST) && (w_vcount_nxt <= VA_LAST);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_hcount <= 11'd0;
         r_vcount <= 10'd0;
         r_hsync  <= ~HPOL;
         r_vsync  <= ~VPOL;
         r_active <= 1'b1;
      end else begin
         r_hcount <= w_hcount_nxt;
         r_vcount <= w_vcount_nxt;
         r_hsync  <= w_hsync_nxt;
         r_vsync  <= w_vsync_nxt;
         r_active <= w_active_nxt;
      end
   end

   assign hcount       = r_hcount;
   assign vcount       = r_vcount;
   assign hsync        = r_hsync;
   assign vsync        = r_vsync;
   assign active_video = r_active;

`ifdef VGA_FRAME_CNT_EN
   logic [15:0] r_frame_count;
   logic        w_frame_wrap;

   assign w_frame_wrap = w_h_wrap & w_v_wrap;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_frame_count <= 16'd0;
      end else if (w_frame_wrap) begin
         r_frame_count <= r_frame_count + 16'd1;
      end
   end

   assign frame_count = r_frame_count;
`endif

endmodule

// File: tb/tb_vga_controller.sv
// Bench: default-mode line vectors plus a small-mode instance checked every
// cycle against an elapsed-time position model, with frame and reset sequences.
`timescale 1ns/1ps
module tb_vga_controller;

   localparam int SHA = 16;
   localparam int SHF = 4;
   localparam int SHS = 6;
   localparam int SHB = 5;
   localparam int SVA = 10;
   localparam int SVF = 2;
   localparam int SVS = 3;
   localparam int SVB = 2;
   localparam int SHT = SHA + SHF + SHS + SHB;
   localparam int SVT = SVA + SVF + SVS + SVB;
   localparam int SFR = SHT * SVT;
   localparam bit SHP = 1'b0;
   localparam bit SVP = 1'b0;

   typedef struct packed {
      logic [10:0] h;
      logic [9:0]  v;
      logic        hs;
      logic        vs;
      logic        av;
      logic [15:0] fc;
   } exp_t;

   typedef struct {
      longint t;
      int     h;
      int     v;
      bit     hs;
      bit     vs;
      bit     av;
   } vec_t;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic        rst_a;
   logic        rst_b;
   logic        hs_a, vs_a, av_a;
   logic        hs_b, vs_b, av_b;
   logic [10:0] hc_a, hc_b;
   logic [9:0]  vc_a, vc_b;
`ifdef VGA_FRAME_CNT_EN
   logic [15:0] fc_a, fc_b;
`endif

   int     checks = 0;
   int     errors = 0;
   bit     done_a = 1'b0;
   bit     done_b = 1'b0;
   longint cnt_a = 0;
   longint cnt_b = 0;

   vga_controller u_def (
      .clk          (clk),
      .reset_n      (rst_a),
      .hsync        (hs_a),
      .vsync        (vs_a),
      .hcount       (hc_a),
      .vcount       (vc_a),
      .active_video (av_a)
`ifdef VGA_FRAME_CNT_EN
      ,
      .frame_count  (fc_a)
`endif
   );

   vga_controller #(
      .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
      .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
      .H_SYNC_POL(0), .V_SYNC_POL(0)
   ) u_small (
      .clk          (clk),
      .reset_n      (rst_b),
      .hsync        (hs_b),
      .vsync        (vs_b),
      .hcount       (hc_b),
      .vcount       (vc_b),
      .active_video (av_b)
`ifdef VGA_FRAME_CNT_EN
      ,
      .frame_count  (fc_b)
`endif
   );

   // Clock edges elapsed since each reset release.
   always @(posedge clk or negedge rst_a)
      if (!rst_a) cnt_a <= 0;
      else        cnt_a <= cnt_a + 1;

   always @(posedge clk or negedge rst_b)
      if (!rst_b) cnt_b <= 0;
      else        cnt_b <= cnt_b + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         if (errors <= 50)
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input longint t);
      exp_t   m;
      longint h, v, f;
      h    = t % SHT;
      v    = (t / SHT) % SVT;
      f    = (t / SFR) % 65536;
      m.h  = 11'(h);
      m.v  = 10'(v);
      m.hs = (h >= SHA + SHF && h < SHA + SHF + SHS) ? SHP : !SHP;
      m.vs = (v >= SVA + SVF && v < SVA + SVF + SVS) ? SVP : !SVP;
      m.av = (h < SHA) && (v < SVA);
      m.fc = 16'(f);
      return m;
   endfunction

   task automatic chk_reset_b(input string tag);
      chk({tag, "_rst_h"}, hc_b, 0);
      chk({tag, "_rst_v"}, vc_b, 0);
      chk({tag, "_rst_hs"}, hs_b, !SHP);
      chk({tag, "_rst_vs"}, vs_b, !SVP);
      chk({tag, "_rst_av"}, av_b, 1);
`ifdef VGA_FRAME_CNT_EN
      chk({tag, "_rst_fc"}, fc_b, 0);
`endif
   endtask

   always @(negedge clk) begin
      exp_t e;
      e = model(cnt_b);
      chk("b_hcount", hc_b, e.h);
      chk("b_vcount", vc_b, e.v);
      chk("b_hsync", hs_b, e.hs);
      chk("b_vsync", vs_b, e.vs);
      chk("b_active", av_b, e.av);
`ifdef VGA_FRAME_CNT_EN
      chk("b_frame_count", fc_b, e.fc);
`endif
   end

   // Default 800x600 mode: one reset window and the first two lines.
   initial begin
      vec_t tbl[13];
      rst_a = 1'b0;
      tbl[0]  = '{0,    0,    0, 0, 0, 1};
      tbl[1]  = '{1,    1,    0, 0, 0, 1};
      tbl[2]  = '{2,    2,    0, 0, 0, 1};
      tbl[3]  = '{799,  799,  0, 0, 0, 1};
      tbl[4]  = '{800,  800,  0, 0, 0, 0};
      tbl[5]  = '{855,  855,  0, 0, 0, 0};
      tbl[6]  = '{856,  856,  0, 1, 0, 0};
      tbl[7]  = '{975,  975,  0, 1, 0, 0};
      tbl[8]  = '{976,  976,  0, 0, 0, 0};
      tbl[9]  = '{1039, 1039, 0, 0, 0, 0};
      tbl[10] = '{1040, 0,    1, 0, 0, 1};
      tbl[11] = '{1840, 800,  1, 0, 0, 0};
      tbl[12] = '{2080, 0,    2, 0, 0, 1};
      fork
         #22 rst_a = 1'b1;
      join_none
      #15;
      foreach (tbl[i]) begin
         while (cnt_a < tbl[i].t) @(negedge clk);
         chk("a_hcount", hc_a, tbl[i].h);
         chk("a_vcount", vc_a, tbl[i].v);
         chk("a_hsync", hs_a, tbl[i].hs);
         chk("a_vsync", vs_a, tbl[i].vs);
         chk("a_active", av_a, tbl[i].av);
`ifdef VGA_FRAME_CNT_EN
         chk("a_frame_count", fc_a, 0);
`endif
      end
      done_a = 1'b1;
   end

   // Small mode: 100 frames, a mid-frame reset, then random resets.
   initial begin
      longint ev[$];
      longint t0, lim, vs_cyc, t_end;
      bit     prev_as, now_as, found;
      rst_b  = 1'b0;
      #22 rst_b = 1'b1;
      prev_as = 1'b0;
      vs_cyc  = 0;
      while (cnt_b < 100 * SFR) begin
         @(negedge clk);
         now_as = (vs_b == SVP);
         if (now_as) vs_cyc++;
         if (prev_as && !now_as) ev.push_back(cnt_b);
         prev_as = now_as;
      end
      chk("b_frame100_h", hc_b, 0);
      chk("b_frame100_v", vc_b, 0);
`ifdef VGA_FRAME_CNT_EN
      chk("b_frame100_fc", fc_b, 100);
`endif
      chk("b_vs_pulses", ev.size(), 100);
      chk("b_vs_cycles", vs_cyc, 100 * SVS * SHT);
      if (ev.size() > 0) chk("b_first_vs_end", ev[0], (SVA + SVF + SVS) * SHT);
      for (int i = 1; i < ev.size(); i++)
         chk("b_vs_period", ev[i] - ev[i-1], SFR);

      t0 = cnt_b + SFR - (cnt_b % SFR);
      while (cnt_b < t0 + 5 * SHT + 8) @(negedge clk);
      chk("b_pre_rst_h", hc_b, 8);
      chk("b_pre_rst_v", vc_b, 5);
      #3 rst_b = 1'b0;
      #1 chk_reset_b("mid");
      repeat ($urandom_range(1, 3)) @(negedge clk);
      #2 rst_b = 1'b1;
      prev_as = 1'b0;
      found   = 1'b0;
      lim     = 0;
      t_end   = -1;
      while (!found && lim < 2 * SFR) begin
         @(negedge clk);
         lim++;
         now_as = (vs_b == SVP);
         if (prev_as && !now_as) begin
            found = 1'b1;
            t_end = cnt_b;
         end
         prev_as = now_as;
      end
      chk("b_rst_first_vs_end", t_end, (SVA + SVF + SVS) * SHT);

      for (int k = 0; k < 8; k++) begin
         repeat ($urandom_range(1, 1200)) @(negedge clk);
         #($urandom_range(1, 8)) rst_b = 1'b0;
         #1 chk_reset_b("rand");
         repeat ($urandom_range(1, 3)) @(negedge clk);
         #2 rst_b = 1'b1;
      end
      repeat (2 * SFR) @(negedge clk);
      done_b = 1'b1;
   end

   initial begin
      fork
         wait (done_a && done_b);
         #5_000_000;
      join_any
      chk("completion", longint'(done_a && done_b), 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
